// File: rtl/peripheral_noc_packet_tx.sv
// Packet transmitter for the peripheral NoC.
// Accepts a descriptor (dest, class, length) and a payload word stream, then
// emits one header flit, the payload flits, and marks the final flit with last.
// Optional build macro PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN appends an XOR
// checksum flit after the payload.

module peripheral_noc_packet_tx #(
  parameter int unsigned FLIT_WIDTH  = 32,
  parameter int unsigned DEST_WIDTH  = 5,
  parameter int unsigned CLASS_WIDTH = 3,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEST_WIDTH-1:0]  req_dest,
  input  logic [CLASS_WIDTH-1:0] req_class,
  input  logic [LW-1:0]          req_len,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [FLIT_WIDTH-1:0]  pl_data,
  input  logic                   pl_valid,
  output logic                   pl_ready,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   len_err
);

  // Header fields must fit in one flit.
  if (DEST_WIDTH + CLASS_WIDTH + LW > FLIT_WIDTH) begin : g_cfg_width_check
    $fatal(1, "peripheral_noc_packet_tx: header fields exceed FLIT_WIDTH");
  end
  if (MAX_LEN < 1) begin : g_cfg_len_check
    $fatal(1, "peripheral_noc_packet_tx: MAX_LEN must be at least 1");
  end

`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StPayload, StChk} state_e;
`else
  typedef enum logic [0:0] {StIdle, StPayload} state_e;
`endif

  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

  state_e                 state_q, state_d;
  logic [LW-1:0]          remaining_q, remaining_d;
  logic [FLIT_WIDTH-1:0]  out_flit_q, out_flit_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;
  logic                   len_err_q, len_err_d;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
  logic [FLIT_WIDTH-1:0]  csum_q, csum_d;
`endif

  logic                   load_ok;
  logic [LW-1:0]          eff_len;
  logic [FLIT_WIDTH-1:0]  header;
  logic                   req_ready_raw;
  logic                   pl_ready_raw;

  // Header assembly from the live descriptor; only used on the accept cycle.
  always_comb begin
    eff_len = (req_len > MaxLen) ? MaxLen : req_len;
    header  = '0;
    header[FLIT_WIDTH-1 -: DEST_WIDTH]              = req_dest;
    header[FLIT_WIDTH-DEST_WIDTH-1 -: CLASS_WIDTH]  = req_class;
    header[LW-1:0]                                  = eff_len;
  end

  // Next-state and handshake logic.
  always_comb begin
    load_ok       = ~out_valid_q | out_ready;
    state_d       = state_q;
    remaining_d   = remaining_q;
    out_flit_d    = out_flit_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;
    len_err_d     = 1'b0;
    req_ready_raw = 1'b0;
    pl_ready_raw  = 1'b0;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    // Held flit consumed and nothing new loaded: drop valid.
    if (load_ok) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        req_ready_raw = load_ok;
        if (req_valid && load_ok) begin
          out_flit_d  = header;
          out_valid_d = 1'b1;
          len_err_d   = (req_len > MaxLen);
          remaining_d = eff_len;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
          csum_d      = header;
          out_last_d  = 1'b0;
          state_d     = (eff_len == '0) ? StChk : StPayload;
`else
          out_last_d  = (eff_len == '0);
          state_d     = (eff_len == '0) ? StIdle : StPayload;
`endif
        end
      end
      StPayload: begin
        pl_ready_raw = load_ok;
        if (pl_valid && load_ok) begin
          out_flit_d  = pl_data;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - LW'(1);
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
          csum_d      = csum_q ^ pl_data;
          out_last_d  = 1'b0;
          if (remaining_q == LW'(1)) state_d = StChk;
`else
          out_last_d  = (remaining_q == LW'(1));
          if (remaining_q == LW'(1)) state_d = StIdle;
`endif
        end
      end
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
      StChk: begin
        if (load_ok) begin
          out_flit_d  = csum_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Readies are masked while reset is asserted so nothing is accepted then.
  assign req_ready = req_ready_raw & ~rst;
  assign pl_ready  = pl_ready_raw & ~rst;
  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign len_err   = len_err_q;
  assign busy      = (state_q != StIdle) | out_valid_q;

endmodule

// File: tb/tb_peripheral_noc_packet_tx.sv
// Scoreboard bench for peripheral_noc_packet_tx: the driver pushes the expected
// flit sequence of each packet, a negedge monitor pops and compares transfers.

module tb_peripheral_noc_packet_tx;

  localparam int unsigned FW = 32;
  localparam int unsigned DW = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned ML = 16;
  localparam int unsigned LW = 5;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] req_dest;
  logic [CW-1:0] req_class;
  logic [LW-1:0] req_len;
  logic          req_valid;
  logic          req_ready;
  logic [FW-1:0] pl_data;
  logic          pl_valid;
  logic          pl_ready;
  logic [FW-1:0] out_flit;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          len_err;

  exp_t          exp_q[$];
  int unsigned   cyc_q[$];
  logic [FW-1:0] dir_pl[$];
  exp_t          mon_e;
  int unsigned   cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            lenerr_exp = 0;
  int            lenerr_seen = 0;
  bit            rdy_rand = 1'b0;

  peripheral_noc_packet_tx #(
    .FLIT_WIDTH (FW),
    .DEST_WIDTH (DW),
    .CLASS_WIDTH(CW),
    .MAX_LEN    (ML),
    .LW         (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_dest (req_dest),
    .req_class(req_class),
    .req_len  (req_len),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .out_flit (out_flit),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: a transfer happens at the next posedge when valid & ready now.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flit: got %h expected none", out_flit);
      end else begin
        mon_e = exp_q.pop_front();
        check("flit", out_flit, mon_e.flit);
        check("last", FW'(out_last), FW'(mon_e.last));
      end
    end
    if (rst === 1'b0 && len_err === 1'b1) lenerr_seen++;
  end

  // Waits for the pending handshake; returns at posedge+1 after it happened.
  task automatic wait_hs(input bit is_req, input string name);
    int n = 0;
    bit ok;
    do begin
      @(negedge clk);
      ok = is_req ? (req_ready === 1'b1) : (pl_ready === 1'b1);
      n++;
      @(posedge clk);
      #1;
    end while (!ok && n < 500);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got no handshake expected one within 500 cycles", name);
    end
  endtask

  // Builds the expected flits from the packet rules, then drives the packet.
  task automatic send_pkt(input logic [DW-1:0] d, input logic [CW-1:0] c,
                          input int unsigned len, input bit gaps);
    int unsigned   eff;
    logic [FW-1:0] hdr;
    logic [FW-1:0] cs;
    logic [FW-1:0] words[$];
    eff = (len > ML) ? ML : len;
    hdr = (FW'(d) << (FW - DW)) | (FW'(c) << (FW - DW - CW)) | FW'(eff);
    for (int i = 0; i < int'(eff); i++) begin
      if (dir_pl.size() != 0) words.push_back(dir_pl.pop_front());
      else words.push_back($urandom());
    end
    cs = hdr;
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
    exp_q.push_back(exp_t'{flit: hdr, last: 1'b0});
    foreach (words[i]) begin
      cs ^= words[i];
      exp_q.push_back(exp_t'{flit: words[i], last: 1'b0});
    end
    exp_q.push_back(exp_t'{flit: cs, last: 1'b1});
`else
    exp_q.push_back(exp_t'{flit: hdr, last: (eff == 0)});
    foreach (words[i]) exp_q.push_back(exp_t'{flit: words[i], last: (i == int'(eff) - 1)});
`endif
    if (len > ML) lenerr_exp++;

    req_dest  = d;
    req_class = c;
    req_len   = LW'(len);
    req_valid = 1'b1;
    wait_hs(1'b1, "req_handshake");
    req_valid = 1'b0;
    req_dest  = DW'($urandom());
    req_class = CW'($urandom());
    req_len   = LW'($urandom());
    foreach (words[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      pl_data  = words[i];
      pl_valid = 1'b1;
      wait_hs(1'b0, "pl_handshake");
      pl_valid = 1'b0;
      pl_data  = $urandom();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d flits outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    // Reset with random inputs.
    req_dest  = DW'($urandom());
    req_class = CW'($urandom());
    req_len   = LW'($urandom());
    req_valid = 1'($urandom());
    pl_data   = $urandom();
    pl_valid  = 1'($urandom());
    out_ready = 1'($urandom());
    rst       = 1'b1;
    @(negedge clk);
    check("rst_out_valid", FW'(out_valid), 0);
    check("rst_req_ready", FW'(req_ready), 0);
    check("rst_busy", FW'(busy), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    pl_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", FW'(req_ready), 1);
    check("post_rst_out_valid", FW'(out_valid), 0);
    check("post_rst_pl_ready", FW'(pl_ready), 0);
    @(posedge clk);
    #1;

    // Directed packets back to back with out_ready held high.
    cyc_q.delete();
    dir_pl = '{32'h11, 32'h22, 32'h33};
    send_pkt(5'h1A, 3'h2, 3, 1'b0);
    send_pkt(5'h01, 3'h0, 0, 1'b0);
    send_pkt(5'h03, 3'h1, 0, 1'b0);
    drain();
`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
    check("b2b_count", FW'(cyc_q.size()), 9);
`else
    check("b2b_count", FW'(cyc_q.size()), 6);
`endif
    for (int i = 0; i + 1 < cyc_q.size(); i++) check("b2b_gap", FW'(cyc_q[i+1] - cyc_q[i]), 1);

    // Downstream stall for 5 cycles while the first payload flit is held.
    dir_pl = '{32'hAAAA0001, 32'hAAAA0002};
    fork
      send_pkt(5'h02, 3'h3, 2, 1'b0);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_flit", out_flit, 32'hAAAA0001);
          check("stall_last", FW'(out_last), 0);
          check("stall_valid", FW'(out_valid), 1);
          check("stall_pl_ready", FW'(pl_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Over-length request is clamped to MAX_LEN.
    send_pkt(5'h07, 3'h5, 20, 1'b0);
    drain();
    check("len_err_pulses", FW'(lenerr_seen), FW'(lenerr_exp));

`ifdef PERIPHERAL_NOC_PACKET_TX_CHECKSUM_EN
    dir_pl = '{32'hF0F0F0F0, 32'h0F0F0F0F};
    send_pkt(5'h00, 3'h0, 2, 1'b0);
    drain();
`endif

    // Randomized packets with payload gaps and backpressure.
    rdy_rand = 1'b1;
    repeat (40) send_pkt(DW'($urandom()), CW'($urandom()), $urandom_range(0, 20), 1'b1);
    drain();
    rdy_rand = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_busy", FW'(busy), 0);
    check("idle_out_valid", FW'(out_valid), 0);
    check("len_err_total", FW'(lenerr_seen), FW'(lenerr_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
